// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write scoreboard and issue/stall/drain control for ID.
// Optional macro SB_WB_BYPASS_EN lets a consumer issue in the producer's writeback cycle.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic       clk_n,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [2:0] id_src1_addr,
    input  logic [2:0] id_src2_addr,
    input  logic       id_uses_src2,
    input  logic [2:0] id_dest_reg_addr,
    input  logic       id_writes_reg,
    input  logic       id_kill,
    input  logic       wb_reg_wea,
    input  logic [2:0] wb_reg_waddr,
    input  logic       drain_req,
    output logic       id_stall,
    output logic       id_issue,
    output logic [7:0] sb_busy,
    output logic       drain_done,
    output logic       sb_err
);

    localparam int NREG = 8;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DRAINED = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [NREG-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]                 sb_busy_q, sb_busy_d;
    logic                       drain_done_q, drain_done_d;
    logic                       sb_err_q, sb_err_d;

    logic [CNT_W-1:0] src1_cnt_s, src2_cnt_s, dest_cnt_s;
    logic             hz1_s, hz2_s, hzf_s, hz_s;
    logic             live_s;
    logic             id_stall_s, id_issue_s;
    logic [NREG-1:0]  nonzero_s;
    logic             all_zero_s;
    logic [NREG-1:0]  inc_s, dec_s;
    logic             underflow_s;

    assign src1_cnt_s = cnt_q[id_src1_addr];
    assign src2_cnt_s = cnt_q[id_src2_addr];
    assign dest_cnt_s = cnt_q[id_dest_reg_addr];
    assign live_s     = id_valid && !id_kill;

`ifdef SB_WB_BYPASS_EN
    // A last pending write landing this cycle is readable by the consumer.
    logic wb_hit1_s, wb_hit2_s;
    assign wb_hit1_s = wb_reg_wea && (wb_reg_waddr == id_src1_addr);
    assign wb_hit2_s = wb_reg_wea && (wb_reg_waddr == id_src2_addr);
    assign hz1_s = (src1_cnt_s != CNT_ZERO) && !((src1_cnt_s == CNT_ONE) && wb_hit1_s);
    assign hz2_s = id_uses_src2 && (src2_cnt_s != CNT_ZERO)
                   && !((src2_cnt_s == CNT_ONE) && wb_hit2_s);
`else
    assign hz1_s = (src1_cnt_s != CNT_ZERO);
    assign hz2_s = id_uses_src2 && (src2_cnt_s != CNT_ZERO);
`endif

    assign hzf_s = id_writes_reg && (dest_cnt_s == CNT_MAX);
    assign hz_s  = hz1_s || hz2_s || hzf_s;

    // Per-register occupancy from the current counts
    always_comb begin
        nonzero_s = {NREG{1'b0}};
        for (int n = 0; n < NREG; n++) begin
            nonzero_s[n] = (cnt_q[n] != CNT_ZERO);
        end
        all_zero_s = (nonzero_s == {NREG{1'b0}});
    end

    // Next-state and issue/stall decode
    always_comb begin
        state_d    = state_q;
        id_stall_s = 1'b0;
        id_issue_s = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (drain_req) begin
                    id_stall_s = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (live_s && hz_s) begin
                    id_stall_s = 1'b1;
                    state_d    = ST_STALL;
                end else begin
                    id_issue_s = live_s;
                    state_d    = ST_RUN;
                end
            end
            ST_STALL: begin
                if (drain_req) begin
                    id_stall_s = 1'b1;
                    state_d    = ST_DRAIN;
                end else if (id_kill) begin
                    state_d = ST_RUN;
                end else if (id_valid && hz_s) begin
                    id_stall_s = 1'b1;
                    state_d    = ST_STALL;
                end else begin
                    id_issue_s = id_valid;
                    state_d    = ST_RUN;
                end
            end
            ST_DRAIN: begin
                id_stall_s = 1'b1;
                if (all_zero_s) begin
                    state_d = ST_DRAINED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAINED: begin
                id_stall_s = 1'b1;
                if (!drain_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_DRAINED;
                end
            end
            default: begin
                id_stall_s = 1'b1;
                state_d    = ST_RUN;
            end
        endcase
    end

    // Pending-count update; a simultaneous issue and writeback cancel out
    always_comb begin
        cnt_d       = cnt_q;
        inc_s       = {NREG{1'b0}};
        dec_s       = {NREG{1'b0}};
        underflow_s = 1'b0;
        for (int n = 0; n < NREG; n++) begin
            inc_s[n] = id_issue_s && id_writes_reg && (id_dest_reg_addr == 3'(n));
            dec_s[n] = wb_reg_wea && (wb_reg_waddr == 3'(n));
            if (inc_s[n] && !dec_s[n]) begin
                cnt_d[n] = cnt_q[n] + CNT_ONE;
            end else if (dec_s[n] && !inc_s[n]) begin
                if (cnt_q[n] == CNT_ZERO) begin
                    underflow_s = 1'b1;
                    cnt_d[n]    = CNT_ZERO;
                end else begin
                    cnt_d[n] = cnt_q[n] - CNT_ONE;
                end
            end else begin
                cnt_d[n] = cnt_q[n];
            end
        end
    end

    // Status outputs; drain_done falls on the same edge that leaves DRAINED
    always_comb begin
        sb_busy_d    = nonzero_s;
        drain_done_d = (state_q == ST_DRAINED) && (state_d == ST_DRAINED);
        sb_err_d     = sb_err_q || underflow_s;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_n) begin
        if (rst) begin
            state_q      <= ST_RUN;
            cnt_q        <= {(NREG*CNT_W){1'b0}};
            sb_busy_q    <= 8'h00;
            drain_done_q <= 1'b0;
            sb_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sb_busy_q    <= sb_busy_d;
            drain_done_q <= drain_done_d;
            sb_err_q     <= sb_err_d;
        end
    end

    assign id_stall   = id_stall_s;
    assign id_issue   = id_issue_s;
    assign sb_busy    = sb_busy_q;
    assign drain_done = drain_done_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard-style bench for reg_scoreboard: expectations are queued per cycle and checked mid-cycle.
module tb_reg_scoreboard;

    logic       clk_n = 1'b0;
    logic       rst;
    logic       id_valid, id_uses_src2, id_writes_reg, id_kill;
    logic [2:0] id_src1_addr, id_src2_addr, id_dest_reg_addr;
    logic       wb_reg_wea;
    logic [2:0] wb_reg_waddr;
    logic       drain_req;
    logic       id_stall, id_issue, drain_done, sb_err;
    logic [7:0] sb_busy;

    typedef enum int {O_STALL, O_ISSUE, O_BUSY, O_DONE, O_ERR} out_sel_e;
    typedef struct {
        string      tag;
        out_sel_e   sel;
        logic [7:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk_n           (clk_n),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_src1_addr    (id_src1_addr),
        .id_src2_addr    (id_src2_addr),
        .id_uses_src2    (id_uses_src2),
        .id_dest_reg_addr(id_dest_reg_addr),
        .id_writes_reg   (id_writes_reg),
        .id_kill         (id_kill),
        .wb_reg_wea      (wb_reg_wea),
        .wb_reg_waddr    (wb_reg_waddr),
        .drain_req       (drain_req),
        .id_stall        (id_stall),
        .id_issue        (id_issue),
        .sb_busy         (sb_busy),
        .drain_done      (drain_done),
        .sb_err          (sb_err)
    );

    always #5 clk_n = ~clk_n;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input out_sel_e sel, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
    endtask

    function automatic logic [7:0] observe(input out_sel_e sel);
        case (sel)
            O_STALL: return {7'd0, id_stall};
            O_ISSUE: return {7'd0, id_issue};
            O_BUSY:  return sb_busy;
            O_DONE:  return {7'd0, drain_done};
            O_ERR:   return {7'd0, sb_err};
            default: return 8'hxx;
        endcase
    endfunction

    // Sample mid-cycle, drain this cycle's expectations, then advance past the edge.
    task automatic cyc();
        exp_t e;
        @(negedge clk_n);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val(e.tag, observe(e.sel), e.val);
        end
        @(posedge clk_n);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [2:0] s1, input logic [2:0] s2,
                          input logic u2, input logic [2:0] d, input logic w, input logic k);
        id_valid         = v;
        id_src1_addr     = s1;
        id_src2_addr     = s2;
        id_uses_src2     = u2;
        id_dest_reg_addr = d;
        id_writes_reg    = w;
        id_kill          = k;
    endtask

    task automatic set_wb(input logic we, input logic [2:0] a);
        wb_reg_wea   = we;
        wb_reg_waddr = a;
    endtask

    task automatic idle();
        set_id(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        set_wb(1'b0, 3'd0);
    endtask

    task automatic exp_si(input string tag, input logic s, input logic i);
        expect_out({tag, "_stall"}, O_STALL, {7'd0, s});
        expect_out({tag, "_issue"}, O_ISSUE, {7'd0, i});
    endtask

    initial begin
        rst       = 1'b1;
        drain_req = 1'b0;
        idle();
        repeat (2) @(posedge clk_n);
        #1;
        rst = 1'b0;

        // reset state
        exp_si("rst", 1'b0, 1'b0);
        expect_out("rst_busy", O_BUSY, 8'h00);
        expect_out("rst_done", O_DONE, 8'h00);
        expect_out("rst_err",  O_ERR,  8'h00);
        cyc();

        // basic issue: src1=2 src2=5 dest=1
        set_id(1'b1, 3'd2, 3'd5, 1'b1, 3'd1, 1'b1, 1'b0);
        exp_si("basic", 1'b0, 1'b1);
        cyc();
        idle();
        exp_si("basic_idle", 1'b0, 1'b0);
        cyc();
        set_wb(1'b1, 3'd1);
        expect_out("basic_busy", O_BUSY, 8'h02);
        cyc();
        idle();
        cyc();
        expect_out("basic_busy_clr", O_BUSY, 8'h00);
        cyc();

        // RAW on r4: producer, consumer stalls, writeback three cycles after issue
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd4, 1'b1, 1'b0);
        exp_si("raw_prod", 1'b0, 1'b1);
        cyc();
        set_id(1'b1, 3'd4, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        exp_si("raw_c1", 1'b1, 1'b0);
        cyc();
        exp_si("raw_c2", 1'b1, 1'b0);
        cyc();
        set_wb(1'b1, 3'd4);
`ifdef SB_WB_BYPASS_EN
        exp_si("raw_wb", 1'b0, 1'b1);
        cyc();
        idle();
        exp_si("raw_after", 1'b0, 1'b0);
        cyc();
`else
        exp_si("raw_wb", 1'b1, 1'b0);
        cyc();
        set_wb(1'b0, 3'd0);
        exp_si("raw_after", 1'b0, 1'b1);
        cyc();
`endif
        idle();
        exp_si("raw_run", 1'b0, 1'b0);
        cyc();

        // fill r6 to max, fourth write stalls on hzf
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            exp_si("fill", 1'b0, 1'b1);
            cyc();
        end
        exp_si("full", 1'b1, 1'b0);
        cyc();
        set_wb(1'b1, 3'd6);
        exp_si("full_wb", 1'b1, 1'b0);
        cyc();
        set_wb(1'b0, 3'd0);
        exp_si("full_issue", 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd6, 1'b1, 1'b0);
        expect_out("full_busy", O_BUSY, 8'h40);
        exp_si("full_again", 1'b1, 1'b0);
        cyc();
        id_kill = 1'b1;
        exp_si("kill_stall", 1'b0, 1'b0);
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            set_wb(1'b1, 3'd6);
            cyc();
        end
        idle();
        cyc();
        expect_out("full_busy_clr", O_BUSY, 8'h00);
        cyc();

        // kill in RUN never touches counters
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b1);
        exp_si("kill_run", 1'b0, 1'b0);
        cyc();
        idle();
        cyc();
        expect_out("kill_busy", O_BUSY, 8'h00);
        cyc();

        // same-cycle issue and writeback on r0 with count 1
        set_id(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        exp_si("same_a", 1'b0, 1'b1);
        cyc();
        set_wb(1'b1, 3'd0);
        exp_si("same_b", 1'b0, 1'b1);
        cyc();
        idle();
        cyc();
        set_wb(1'b1, 3'd0);
        expect_out("same_busy", O_BUSY, 8'h01);
        cyc();
        idle();
        cyc();
        expect_out("same_busy_clr", O_BUSY, 8'h00);
        expect_out("same_err", O_ERR, 8'h00);
        cyc();

        // drain with writes to r3 and r5 pending
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd3, 1'b1, 1'b0);
        exp_si("dr_w3", 1'b0, 1'b1);
        cyc();
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd5, 1'b1, 1'b0);
        exp_si("dr_w5", 1'b0, 1'b1);
        cyc();
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd2, 1'b1, 1'b0);
        drain_req = 1'b1;
        exp_si("dr_req", 1'b1, 1'b0);
        cyc();
        set_wb(1'b1, 3'd3);
        exp_si("dr_wb3", 1'b1, 1'b0);
        cyc();
        set_wb(1'b1, 3'd5);
        exp_si("dr_wb5", 1'b1, 1'b0);
        expect_out("dr_done_wb5", O_DONE, 8'h00);
        cyc();
        set_wb(1'b0, 3'd0);
        exp_si("dr_empty", 1'b1, 1'b0);
        expect_out("dr_done_early", O_DONE, 8'h00);
        cyc();
        expect_out("dr_drained_stall", O_STALL, 8'h01);
        cyc();
        exp_si("dr_hold", 1'b1, 1'b0);
        expect_out("dr_done", O_DONE, 8'h01);
        cyc();
        drain_req = 1'b0;
        exp_si("dr_release", 1'b1, 1'b0);
        expect_out("dr_done_hold", O_DONE, 8'h01);
        cyc();
        exp_si("dr_resume", 1'b0, 1'b1);
        expect_out("dr_done_clr", O_DONE, 8'h00);
        cyc();
        idle();
        set_wb(1'b1, 3'd2);
        cyc();

        // writeback to r7 with count 0 sets a sticky error
        set_wb(1'b1, 3'd7);
        expect_out("err_before", O_ERR, 8'h00);
        cyc();
        idle();
        for (int k = 0; k < 3; k++) begin
            expect_out("err_sticky", O_ERR, 8'h01);
            cyc();
        end

        // reset mid-operation with a write to r1 pending
        set_id(1'b1, 3'd0, 3'd0, 1'b0, 3'd1, 1'b1, 1'b0);
        exp_si("mid_prod", 1'b0, 1'b1);
        cyc();
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        set_id(1'b1, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
        exp_si("mid_rst", 1'b0, 1'b1);
        expect_out("mid_rst_err",  O_ERR,  8'h00);
        expect_out("mid_rst_busy", O_BUSY, 8'h00);
        cyc();
        idle();
        set_wb(1'b1, 3'd1);
        cyc();
        idle();
        expect_out("mid_late_wb_err", O_ERR, 8'h01);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
